// File: rtl/series_ctrl_if.sv
// series_ctrl_if: host/datapath <-> series_ctrl control bundle.
//   start, abort : host requests into the controller
//   co           : datapath counter carry (address == 15)
//   ready, done  : host handshake status
//   zx..s0       : datapath clear/init/load/increment strobes and mux select
// Modports: master = controller side, slave = host/datapath side.
interface series_ctrl_if;
  logic start;
  logic abort;
  logic co;
  logic ready;
  logic done;
  logic zx;
  logic zt;
  logic zr;
  logic zc;
  logic initx;
  logic initt;
  logic initr;
  logic ldx;
  logic ldt;
  logic ldr;
  logic ldc;
  logic enc;
  logic s0;

  modport master (
    input  start, abort, co,
    output ready, done, zx, zt, zr, zc, initx, initt, initr,
           ldx, ldt, ldr, ldc, enc, s0
  );

  modport slave (
    output start, abort, co,
    input  ready, done, zx, zt, zr, zc, initx, initt, initr,
           ldx, ldt, ldr, ldc, enc, s0
  );
endinterface

// File: rtl/series_ctrl.sv
// series_ctrl: control FSM for the 16-term Taylor-series datapath.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - series_ctrl_if.master: start/abort/co in; ready/done and all
//          datapath strobes out, decoded from the current state
// Optional feature: define SERIES_START_QUEUE_EN to remember a start request
// that arrives while busy and launch it from IDLE.
module series_ctrl (
  input  logic         clk,
  input  logic         rst,
  series_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_MULX = 3'd2,
    S_MULC = 3'd3,
    S_ACC  = 3'd4,
    S_DONE = 3'd5,
    S_CLR  = 3'd6
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   go_c;

`ifdef SERIES_START_QUEUE_EN
  logic pend_q;
  logic pend_d;

  // A queued request launches just like a live start.
  assign go_c = bus.start | pend_q;

  // Abort clears first, entering INIT consumes the request, busy start sets it.
  always_comb begin
    pend_d = pend_q;
    if (bus.abort) begin
      pend_d = 1'b0;
    end else if (state_d == S_INIT) begin
      pend_d = 1'b0;
    end else if ((state_q != S_IDLE) && bus.start) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end
`else
  assign go_c = bus.start;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and state-decoded strobes. Abort in a working state suppresses
  // that state's strobes in the same cycle so no partial update reaches the
  // datapath before CLR wipes it.
  always_comb begin
    state_d   = S_IDLE;
    bus.ready = 1'b0;
    bus.done  = 1'b0;
    bus.zx    = 1'b0;
    bus.zt    = 1'b0;
    bus.zr    = 1'b0;
    bus.zc    = 1'b0;
    bus.initx = 1'b0;
    bus.initt = 1'b0;
    bus.initr = 1'b0;
    bus.ldx   = 1'b0;
    bus.ldt   = 1'b0;
    bus.ldr   = 1'b0;
    bus.ldc   = 1'b0;
    bus.enc   = 1'b0;
    bus.s0    = 1'b0;

    case (state_q)
      S_IDLE: begin
        bus.ready = 1'b1;
        // Abort beats start while idle.
        state_d = (go_c && !bus.abort) ? S_INIT : S_IDLE;
      end
      S_INIT: begin
        if (bus.abort) begin
          state_d = S_CLR;
        end else begin
          bus.ldx   = 1'b1;
          bus.initt = 1'b1;
          bus.initr = 1'b1;
          bus.zc    = 1'b1;
          state_d   = S_MULX;
        end
      end
      S_MULX: begin
        if (bus.abort) begin
          state_d = S_CLR;
        end else begin
          bus.ldt = 1'b1;
          state_d = S_MULC;
        end
      end
      S_MULC: begin
        if (bus.abort) begin
          state_d = S_CLR;
        end else begin
          bus.ldt = 1'b1;
          bus.s0  = 1'b1;
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        if (bus.abort) begin
          state_d = S_CLR;
        end else begin
          bus.ldr = 1'b1;
          bus.enc = 1'b1;
          // co reflects the address before this cycle's increment.
          state_d = bus.co ? S_DONE : S_MULX;
        end
      end
      S_DONE: begin
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end
      S_CLR: begin
        bus.zx  = 1'b1;
        bus.zt  = 1'b1;
        bus.zr  = 1'b1;
        bus.zc  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
